// File: rtl/mul_rr_arbiter_pkg.sv
// Shared types and defaults for the round-robin multiplier arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mul_arb_pkg;

   localparam int DEF_WIDTH   = 32;
   localparam int DEF_NUM_REQ = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      DRAIN   = 2'd2,
      RESPOND = 2'd3
   } arb_state_t;

endpackage

// File: rtl/mul_rr_arbiter_if.sv
// Requester-side and multiplier-side handshake bundle for the arbiter.
// Latency: none (wires only).
// Backpressure: four-phase req/ack on both sides; master = arbiter, slave = environment.
interface mul_rr_arbiter_if
   import mul_arb_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int NUM_REQ = DEF_NUM_REQ
);

   logic [NUM_REQ-1:0]       req;
   logic [NUM_REQ*WIDTH-1:0] a_in;
   logic [NUM_REQ*WIDTH-1:0] b_in;
   logic [NUM_REQ-1:0]       ack;
   logic [WIDTH-1:0]         out;
   logic                     mul_req;
   logic [WIDTH-1:0]         mul_a;
   logic [WIDTH-1:0]         mul_b;
   logic [WIDTH-1:0]         mul_out;
   logic                     mul_ack;

   modport master (
      input  req, a_in, b_in, mul_out, mul_ack,
      output ack, out, mul_req, mul_a, mul_b
   );

   modport slave (
      output req, a_in, b_in, mul_out, mul_ack,
      input  ack, out, mul_req, mul_a, mul_b
   );

endinterface

// File: rtl/mul_rr_arbiter_rr_pick.sv
// Finds the first set request at or after the pointer, wrapping around.
// Latency: purely combinational.
// Backpressure: none; vld_o low when no request is set.
module rr_pick
   import mul_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic               vld_o,
   output logic [IDX_W-1:0]   idx_o
);

   logic [IDX_W-1:0] j;

   // Scan from the farthest offset down so the nearest set bit wins last.
   always_comb begin
      vld_o = 1'b0;
      idx_o = '0;
      j     = '0;
      for (int off = NUM_REQ - 1; off >= 0; off--) begin
         j = IDX_W'((int'(ptr_i) + off) % NUM_REQ);
         if (req_i[j]) begin
            vld_o = 1'b1;
            idx_o = j;
         end
      end
   end

endmodule

// File: rtl/mul_rr_arbiter.sv
// Round-robin sharing of one four-phase multiplier among NUM_REQ requesters.
// Latency: ack rises 3 cycles + multiplier latency after the grant cycle; >=1 idle cycle between jobs.
// Backpressure: requests sampled only in IDLE; ack held until the granted req drops. MUL_ARB_STATS_EN adds busy/job counters.
module mul_rr_arbiter
   import mul_arb_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int NUM_REQ = DEF_NUM_REQ
) (
   input  logic             clk,
   input  logic             rst,
`ifdef MUL_ARB_STATS_EN
   output logic [31:0]      stat_busy,
   output logic [31:0]      stat_jobs,
`endif
   mul_rr_arbiter_if.master bus
);

   localparam int IDX_W = $clog2(NUM_REQ);

   arb_state_t         state_q, state_d;
   logic [IDX_W-1:0]   gnt_q;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [WIDTH-1:0]   mul_a_q, mul_b_q;
   logic [WIDTH-1:0]   res_q, out_q;
   logic               pick_vld;
   logic [IDX_W-1:0]   pick_idx;
   logic               req_g;
   logic [WIDTH-1:0]   a_arr [NUM_REQ];
   logic [WIDTH-1:0]   b_arr [NUM_REQ];

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign a_arr[gi] = bus.a_in[gi*WIDTH +: WIDTH];
      assign b_arr[gi] = bus.b_in[gi*WIDTH +: WIDTH];
   end

   rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
      .req_i (bus.req),
      .ptr_i (ptr_q),
      .vld_o (pick_vld),
      .idx_o (pick_idx)
   );

   assign req_g = bus.req[gnt_q];
   assign ptr_d = (gnt_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // Next-state: issue, wait ack, wait ack release, wait requester release.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (pick_vld)     state_d = ISSUE;
         ISSUE:   if (bus.mul_ack)  state_d = DRAIN;
         DRAIN:   if (!bus.mul_ack) state_d = RESPOND;
         RESPOND: if (!req_g)       state_d = IDLE;
         default:                   state_d = IDLE;
      endcase
   end

   // Datapath: latch grant/operands, capture product, publish result, advance pointer on completion.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gnt_q   <= '0;
         ptr_q   <= '0;
         mul_a_q <= '0;
         mul_b_q <= '0;
         res_q   <= '0;
         out_q   <= '0;
      end else begin
         case (state_q)
            IDLE: if (pick_vld) begin
               gnt_q   <= pick_idx;
               mul_a_q <= a_arr[pick_idx];
               mul_b_q <= b_arr[pick_idx];
            end
            ISSUE:   if (bus.mul_ack)  res_q <= bus.mul_out;
            DRAIN:   if (!bus.mul_ack) out_q <= res_q;
            RESPOND: if (!req_g)       ptr_q <= ptr_d;
            default: ;
         endcase
      end
   end

   // Outputs decoded from state; ack is one-hot on the granted requester during RESPOND.
   always_comb begin
      bus.ack        = '0;
      bus.mul_req    = (state_q == ISSUE);
      bus.mul_a      = mul_a_q;
      bus.mul_b      = mul_b_q;
      bus.out        = out_q;
      if (state_q == RESPOND) bus.ack[gnt_q] = 1'b1;
   end

`ifdef MUL_ARB_STATS_EN
   logic [31:0] busy_q, jobs_q;

   // Saturating counters: non-idle cycles and completed jobs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_q <= '0;
         jobs_q <= '0;
      end else begin
         if (state_q != IDLE && busy_q != '1) busy_q <= busy_q + 32'd1;
         if (state_q == RESPOND && !req_g && jobs_q != '1) jobs_q <= jobs_q + 32'd1;
      end
   end

   assign stat_busy = busy_q;
   assign stat_jobs = jobs_q;
`endif

endmodule

// File: tb/tb_mul_rr_arbiter.sv
// Bench for the round-robin multiplier arbiter.
// Latency: n/a.
// Backpressure: n/a.
module tb_mul_rr_arbiter;

   localparam int W = 32;
   localparam int N = 4;

   typedef struct {
      int          who;
      logic [31:0] prod;
      int          t0;
   } job_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mul_rr_arbiter_if #(.WIDTH(W), .NUM_REQ(N)) bus ();

`ifdef MUL_ARB_STATS_EN
   logic [31:0] stat_busy, stat_jobs;
`endif

   mul_rr_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
      .clk       (clk),
      .rst       (rst),
`ifdef MUL_ARB_STATS_EN
      .stat_busy (stat_busy),
      .stat_jobs (stat_jobs),
`endif
      .bus       (bus)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // ---------------- behavioural multiplier ----------------
   int fixed_lat = 0;
   bit spur      = 1'b0;

   initial begin
      int cnt, lat;
      cnt = 0;
      lat = 2;
      bus.mul_ack = 1'b0;
      bus.mul_out = '0;
      forever begin
         @(posedge clk); #1;
         if (!rst) begin
            bus.mul_ack = 1'b0;
            cnt = 0;
         end else if (spur) begin
            bus.mul_ack = 1'b1;
            bus.mul_out = 32'hDEAD_BEEF;
         end else if (bus.mul_req && !bus.mul_ack) begin
            cnt++;
            if (cnt >= ((fixed_lat > 0) ? fixed_lat : lat)) begin
               bus.mul_out = bus.mul_a * bus.mul_b;
               bus.mul_ack = 1'b1;
               cnt = 0;
               lat = $urandom_range(1, 4);
            end
         end else if (!bus.mul_req) begin
            bus.mul_ack = 1'b0;
         end
      end
   end

   // ---------------- reference model + scoreboard ----------------
   job_t             sb_q[$];
   int               grant_log[$];
   int               m_ptr = 0;
   int               cyc = 0;
   int               busy_sum = 0;
   logic [N-1:0]     prev_req = '0;
   logic [N-1:0]     prev_ack = '0;
   logic [N*W-1:0]   prev_a = '0;
   logic [N*W-1:0]   prev_b = '0;
   logic             prev_mreq = 1'b0;
   job_t             mj;
   int               mw;
   logic [N-1:0]     me;

   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         sb_q.delete();
         m_ptr     = 0;
         prev_req  = '0;
         prev_ack  = '0;
         prev_mreq = 1'b0;
      end else begin
         if (bus.ack != '0) check("ack_onehot", 32'($onehot(bus.ack)), 32'd1);
         // New job issued: winner is the first requester at/after the model pointer.
         if (bus.mul_req && !prev_mreq) begin
            if (prev_req == '0) begin
               check("grant_without_req", 32'(prev_req), 32'd1);
            end else begin
               mw = -1;
               for (int k = 0; k < N; k++)
                  if (mw < 0 && prev_req[(m_ptr + k) % N]) mw = (m_ptr + k) % N;
               mj.who  = mw;
               mj.prod = prev_a[mw*W +: W] * prev_b[mw*W +: W];
               mj.t0   = cyc;
               check("mul_a", bus.mul_a, prev_a[mw*W +: W]);
               check("mul_b", bus.mul_b, prev_b[mw*W +: W]);
               sb_q.push_back(mj);
            end
         end
         if (bus.ack != '0 && prev_ack == '0) begin
            if (sb_q.size() == 0) begin
               check("spurious_ack", 32'(bus.ack), 32'd0);
            end else begin
               mj = sb_q[0];
               me = '0;
               me[mj.who] = 1'b1;
               check("ack_who", 32'(bus.ack), 32'(me));
               check("out", bus.out, mj.prod);
               m_ptr = (mj.who + 1) % N;
               grant_log.push_back(mj.who);
            end
         end
         if (bus.ack == '0 && prev_ack != '0 && sb_q.size() > 0) begin
            mj = sb_q.pop_front();
            busy_sum += cyc - mj.t0;
         end
         prev_req  = bus.req;
         prev_ack  = bus.ack;
         prev_a    = bus.a_in;
         prev_b    = bus.b_in;
         prev_mreq = bus.mul_req;
      end
   end

   // ---------------- requester helpers ----------------
   task automatic do_job(input int i, input logic [31:0] a, input logic [31:0] b,
                         input int hold, output logic [31:0] got);
      int t;
      @(posedge clk); #1;
      bus.a_in[i*W +: W] = a;
      bus.b_in[i*W +: W] = b;
      bus.req[i] = 1'b1;
      t = 0;
      do begin @(negedge clk); t++; end while (!bus.ack[i] && t < 400);
      if (!bus.ack[i]) begin
         check("ack_timeout", 32'(bus.ack[i]), 32'd1);
         @(posedge clk); #1;
         bus.req[i] = 1'b0;
         got = '0;
         return;
      end
      got = bus.out;
      repeat (hold) @(posedge clk);
      @(posedge clk); #1;
      bus.req[i] = 1'b0;
      @(negedge clk); check("ack_held", 32'(bus.ack[i]), 32'd1);
      @(negedge clk); check("ack_fall", 32'(bus.ack[i]), 32'd0);
   endtask

   task automatic run_cont(input int i);
      logic [31:0] g;
      do_job(i, 32'(i + 1), 32'd10, 0, g);
      check("cont_out", g, 32'((i + 1) * 10));
      do_job(i, 32'(i + 1), 32'd10, 0, g);
   endtask

   task automatic run_rand(input int i, input int n);
      logic [31:0] a, b, g;
      repeat (n) begin
         repeat ($urandom_range(0, 4)) @(posedge clk);
         a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
         b = $urandom;
         do_job(i, a, b, $urandom_range(0, 2), g);
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic wait_mul_req(input string nm);
      int t;
      t = 0;
      do begin @(negedge clk); t++; end while (!bus.mul_req && t < 50);
      check(nm, 32'(bus.mul_req), 32'd1);
   endtask

   task automatic wait_ack(input int i, input string nm);
      int t;
      t = 0;
      do begin @(negedge clk); t++; end while (!bus.ack[i] && t < 100);
      check(nm, 32'(bus.ack[i]), 32'd1);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [31:0] g, g0, g3;
      rst      = 1'b0;
      bus.req  = '0;
      bus.a_in = '0;
      bus.b_in = '0;
      repeat (2) @(negedge clk);
      check("rst_ack",     32'(bus.ack),     32'd0);
      check("rst_out",     bus.out,          32'd0);
      check("rst_mul_req", 32'(bus.mul_req), 32'd0);
      check("rst_mul_a",   bus.mul_a,        32'd0);
      check("rst_mul_b",   bus.mul_b,        32'd0);
      @(posedge clk); #1 rst = 1'b1;

      // Single job, then pointer sits at 3: requester 3 beats requester 0.
      grant_log.delete();
      do_job(2, 32'd7, 32'd6, 0, g);
      check("single_out", g, 32'd42);
      fork
         do_job(0, 32'd2, 32'd3, 0, g0);
         do_job(3, 32'd4, 32'd5, 1, g3);
      join
      check("ptr_first",  32'(grant_log[1]), 32'd3);
      check("ptr_second", 32'(grant_log[2]), 32'd0);

      // Truncation to the low word.
      do_job(0, 32'hFFFF_FFFF, 32'd2, 0, g);
      check("trunc_out", g, 32'hFFFF_FFFE);

      // Multiplier ack while idle is ignored.
      @(posedge clk); #1 spur = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("spur_mul_req", 32'(bus.mul_req), 32'd0);
         check("spur_ack",     32'(bus.ack),     32'd0);
      end
      @(posedge clk); #1 spur = 1'b0;
      repeat (3) @(posedge clk);

      // All four requesting continuously from reset.
      do_reset();
      grant_log.delete();
      fork
         run_cont(0);
         run_cont(1);
         run_cont(2);
         run_cont(3);
      join
      check("cont_log_size", 32'(grant_log.size() >= 5), 32'd1);
      for (int k = 0; k < 5; k++) check("cont_order", 32'(grant_log[k]), 32'(k % N));

      // Reset while the multiplier is still working.
      fixed_lat = 8;
      @(posedge clk); #1;
      bus.a_in[3*W +: W] = 32'd5;
      bus.b_in[3*W +: W] = 32'd5;
      bus.req[3] = 1'b1;
      wait_mul_req("rm_issue");
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check("rm_mul_req", 32'(bus.mul_req), 32'd0);
      check("rm_ack",     32'(bus.ack),     32'd0);
      check("rm_out",     bus.out,          32'd0);
      bus.req[3] = 1'b0;
      fixed_lat = 0;
      @(posedge clk); #1 rst = 1'b1;
      do_job(1, 32'd3, 32'd3, 0, g);
      check("rm_after_out", g, 32'd9);

      // Early drop by requester 0 while the job is in flight; requester 1 follows.
      fixed_lat = 4;
      grant_log.delete();
      @(posedge clk); #1;
      bus.a_in[0 +: W] = 32'd4;
      bus.b_in[0 +: W] = 32'd5;
      bus.req[0] = 1'b1;
      wait_mul_req("ed_issue");
      @(posedge clk); #1;
      bus.req[0] = 1'b0;
      bus.a_in[W +: W] = 32'd6;
      bus.b_in[W +: W] = 32'd7;
      bus.req[1] = 1'b1;
      wait_ack(0, "ed_ack_hi");
      check("ed_out", bus.out, 32'd20);
      @(negedge clk);
      check("ed_ack_1cyc", 32'(bus.ack[0]), 32'd0);
      fixed_lat = 0;
      wait_ack(1, "ed_next_ack");
      check("ed_next_out", bus.out, 32'd42);
      @(posedge clk); #1 bus.req[1] = 1'b0;
      repeat (2) @(negedge clk);
      check("ed_log_size", 32'(grant_log.size()), 32'd2);
      check("ed_next_grant", 32'(grant_log[1]), 32'd1);

      // Randomized traffic from all requesters.
      fork
         run_rand(0, 8);
         run_rand(1, 8);
         run_rand(2, 8);
         run_rand(3, 8);
      join

`ifdef MUL_ARB_STATS_EN
      do_reset();
      busy_sum = 0;
      do_job(2, 32'd2, 32'd2, 0, g);
      do_job(2, 32'd3, 32'd2, 0, g);
      do_job(2, 32'd4, 32'd2, 0, g);
      repeat (2) @(negedge clk);
      check("stat_jobs", stat_jobs, 32'd3);
      check("stat_busy", stat_busy, 32'(busy_sum));
`endif

      repeat (5) @(negedge clk);
      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
